// File: rtl/ram_bubble_sorter.sv
// ram_bubble_sorter
//
// In-place bubble sorter for a packet buffer held in an external true-dual-port RAM with
// 1-cycle read latency. A start pulse sorts words 0..last_addr_i in ascending or descending
// order. Each pass is one word shorter than the previous one, and the sort stops after the
// first pass that makes no swaps.
//
// Port A always addresses word j and port B word j+1. A swap writes each port's read data back
// through the other port in the compare cycle. The next read is issued in the following cycle,
// so no read-after-write hazard exists.
//
// Ports
//   clk_i                  clock
//   srst_i                 asynchronous, active-high reset
//   last_addr_i            index of last valid word (latched at start)
//   desc_i                 1 = descending, 0 = ascending (latched at start)
//   start_i                start pulse, accepted only while idle
//   busy_o                 high while reading/comparing
//   done_o                 one-cycle pulse when the buffer is sorted
//   addr_a_o / addr_b_o    RAM port A/B address (j, j+1)
//   data_a_o / data_b_o    RAM port A/B write data (crossed read data)
//   we_a_o / we_b_o        RAM port A/B write enable
//   q_a_i / q_b_i          RAM port A/B read data
//   passes_o               passes executed in the last sort
//   swaps_o                swaps performed in the last sort
//
// Optional feature: define SORT_STATS_EN to build the saturating pass and swap counters.
// Without it, passes_o and swaps_o are tied to zero.

module ram_bubble_sorter #(
    parameter int unsigned  DWIDTH      = 8,
    parameter int unsigned  MAX_PKT_LEN = 16,
    localparam int unsigned AW          = $clog2(MAX_PKT_LEN)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [AW-1:0]     last_addr_i,
    input  logic              desc_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [AW-1:0]     addr_a_o,
    output logic [AW-1:0]     addr_b_o,
    output logic [DWIDTH-1:0] data_a_o,
    output logic [DWIDTH-1:0] data_b_o,
    output logic              we_a_o,
    output logic              we_b_o,
    input  logic [DWIDTH-1:0] q_a_i,
    input  logic [DWIDTH-1:0] q_b_i,
    output logic [AW-1:0]     passes_o,
    output logic [2*AW-1:0]   swaps_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRd,
        StCmp,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] j_q, j_d;
    logic [AW-1:0] bound_q, bound_d;
    logic          swapped_q, swapped_d;
    logic          desc_q, desc_d;

    logic [AW-1:0] j_inc;
    logic          need_swap;
    logic          pass_end;
    logic          we;
    logic          pass_start;
    logic          swap_evt;
    logic          stats_clr;

    // Pair (j, j+1). The wrap of j+1 is never reached while sorting.
    assign j_inc    = j_q + AW'(1);
    assign addr_a_o = j_q;
    assign addr_b_o = j_inc;

    // A swap writes each word into the other slot.
    assign data_a_o = q_b_i;
    assign data_b_o = q_a_i;
    assign we_a_o   = we;
    assign we_b_o   = we;

    // Equal words never swap, which keeps the sort stable.
    assign need_swap = desc_q ? (q_a_i < q_b_i) : (q_a_i > q_b_i);
    assign pass_end  = (j_inc == bound_q);

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q   <= StIdle;
            j_q       <= '0;
            bound_q   <= '0;
            swapped_q <= 1'b0;
            desc_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            bound_q   <= bound_d;
            swapped_q <= swapped_d;
            desc_q    <= desc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        bound_d    = bound_q;
        swapped_d  = swapped_q;
        desc_d     = desc_q;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        we         = 1'b0;
        pass_start = 1'b0;
        swap_evt   = 1'b0;
        stats_clr  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    bound_d   = last_addr_i;
                    desc_d    = desc_i;
                    j_d       = '0;
                    swapped_d = 1'b0;
                    stats_clr = 1'b1;
                    if (last_addr_i == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d    = StRd;
                        pass_start = 1'b1;
                    end
                end
            end

            StRd: begin
                // Addresses are on the RAM; data comes back in the compare cycle.
                busy_o  = 1'b1;
                state_d = StCmp;
            end

            StCmp: begin
                busy_o = 1'b1;
                if (need_swap) begin
                    we        = 1'b1;
                    swapped_d = 1'b1;
                    swap_evt  = 1'b1;
                end
                if (pass_end) begin
                    // A pass without swaps, or a final single-pair pass, ends the sort.
                    if ((swapped_q || need_swap) && (bound_q > AW'(1))) begin
                        bound_d    = bound_q - AW'(1);
                        j_d        = '0;
                        swapped_d  = 1'b0;
                        state_d    = StRd;
                        pass_start = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    j_d     = j_inc;
                    state_d = StRd;
                end
            end

            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef SORT_STATS_EN
    logic [AW-1:0]   passes_q, passes_d;
    logic [2*AW-1:0] swaps_q, swaps_d;

    // Cleared on an accepted start; saturate at all-ones; hold until the next start.
    always_comb begin
        passes_d = passes_q;
        swaps_d  = swaps_q;
        if (stats_clr) begin
            passes_d = '0;
            swaps_d  = '0;
        end
        if (pass_start && (passes_d != '1)) begin
            passes_d = passes_d + AW'(1);
        end
        if (swap_evt && (swaps_d != '1)) begin
            swaps_d = swaps_d + (2*AW)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            passes_q <= '0;
            swaps_q  <= '0;
        end else begin
            passes_q <= passes_d;
            swaps_q  <= swaps_d;
        end
    end

    assign passes_o = passes_q;
    assign swaps_o  = swaps_q;
`else
    logic unused_stats;
    assign unused_stats = pass_start ^ swap_evt ^ stats_clr;
    assign passes_o     = '0;
    assign swaps_o      = '0;
`endif

endmodule

// File: tb/tb_ram_bubble_sorter.sv
// Bench for ram_bubble_sorter. It holds a 1-cycle-latency dual-port RAM model and checks
// each sort against a reference model. The reference gives the result buffer, the cycle
// count, the write count and the statistics.

module tb_ram_bubble_sorter;

    localparam int unsigned DW  = 8;
    localparam int unsigned MAX = 16;
    localparam int unsigned AW  = $clog2(MAX);
    localparam int unsigned RW  = 4 + 5 * AW;

    typedef logic [DW-1:0] arr_t [MAX];

    logic          clk_i = 1'b0;
    logic          srst_i = 1'b1;
    logic [AW-1:0] last_addr_i = '0;
    logic          desc_i = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, we_a_o, we_b_o;
    logic [AW-1:0] addr_a_o, addr_b_o, passes_o;
    logic [DW-1:0] data_a_o, data_b_o;
    logic [DW-1:0] q_a = '0, q_b = '0;
    logic [2*AW-1:0] swaps_o;

    logic [DW-1:0] mem [MAX];
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    ram_bubble_sorter #(
        .DWIDTH      (DW),
        .MAX_PKT_LEN (MAX)
    ) dut (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .last_addr_i (last_addr_i),
        .desc_i      (desc_i),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .addr_a_o    (addr_a_o),
        .addr_b_o    (addr_b_o),
        .data_a_o    (data_a_o),
        .data_b_o    (data_b_o),
        .we_a_o      (we_a_o),
        .we_b_o      (we_b_o),
        .q_a_i       (q_a),
        .q_b_i       (q_b),
        .passes_o    (passes_o),
        .swaps_o     (swaps_o)
    );

    // True-dual-port RAM with registered read (read-before-write).
    always @(posedge clk_i) begin
        if (ld_we) mem[ld_addr] <= ld_data;
        if (we_a_o) mem[addr_a_o] <= data_a_o;
        if (we_b_o) mem[addr_b_o] <= data_b_o;
        q_a <= mem[addr_a_o];
        q_b <= mem[addr_b_o];
    end

    // Reference: the sorted buffer, inversion count as the swap count, and the early-exit
    // pass schedule that gives the pass count and busy cycles.
    function automatic void model(input arr_t a, input int l, input bit d, output arr_t o,
                                  output int np, output int ns, output int nb);
        int  b;
        bit  any;
        logic [DW-1:0] t;
        o  = a;
        np = 0;
        ns = 0;
        nb = 0;
        for (int i = 0; i <= l; i++)
            for (int k = i + 1; k <= l; k++)
                if (d ? (a[i] < a[k]) : (a[i] > a[k])) ns++;
        b = l;
        while (b >= 1) begin
            np++;
            nb += 2 * b;
            any = 1'b0;
            for (int i = 0; i < b; i++) begin
                if (d ? (o[i] < o[i+1]) : (o[i] > o[i+1])) begin
                    t      = o[i];
                    o[i]   = o[i+1];
                    o[i+1] = t;
                    any    = 1'b1;
                end
            end
            b--;
            if (!any) b = 0;
        end
        if (np > (2**AW - 1)) np = 2**AW - 1;
        if (ns > (2**(2*AW) - 1)) ns = 2**(2*AW) - 1;
    endfunction

    task automatic load_ram(input arr_t a);
        for (int i = 0; i < MAX; i++) begin
            @(negedge clk_i);
            ld_we   = 1'b1;
            ld_addr = AW'(i);
            ld_data = a[i];
        end
        @(negedge clk_i);
        ld_we = 1'b0;
    endtask

    task automatic run_sort(input string name, input arr_t init, input int l, input bit d,
                            input bit poke);
        arr_t exp_o;
        int   np, ns, nb;
        int   k, done_k, nbusy, nwe, nmis, nover;
        bit   got, same;
        logic [AW-1:0]   exp_p;
        logic [2*AW-1:0] exp_s;

        load_ram(init);
        model(init, l, d, exp_o, np, ns, nb);
`ifdef SORT_STATS_EN
        exp_p = AW'(np);
        exp_s = (2*AW)'(ns);
`else
        exp_p = '0;
        exp_s = '0;
`endif
        @(negedge clk_i);
        start_i     = 1'b1;
        last_addr_i = AW'(l);
        desc_i      = d;
        @(negedge clk_i);
        start_i     = 1'b0;
        last_addr_i = AW'($urandom);
        desc_i      = 1'($urandom);
        k = 1; done_k = 0; nbusy = 0; nwe = 0; nmis = 0; nover = 0; got = 1'b0;
        while (k <= 1000 && !got) begin
            if (busy_o) nbusy++;
            if (we_a_o || we_b_o) nwe++;
            if (we_a_o !== we_b_o) nmis++;
            if (done_o) begin
                got    = 1'b1;
                done_k = k;
                if (busy_o) nover++;
            end
            if (poke && k == 3) begin
                start_i     = 1'b1;
                last_addr_i = AW'($urandom);
                desc_i      = ~d;
            end
            if (poke && k == 4) start_i = 1'b0;
            if (!got) begin
                @(negedge clk_i);
                k++;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s done_timeout: got no done_o in %0d cycles, want done at %0d",
                     name, k - 1, nb + 1);
        end else begin
            total++;
            if (done_k != nb + 1) begin
                bad++;
                $display("FAIL %s done_cycle: got N+%0d want N+%0d", name, done_k, nb + 1);
            end
        end
        total++;
        if (nbusy != nb) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, nbusy, nb);
        end
        total++;
        if (nwe != ns) begin
            bad++;
            $display("FAIL %s write_cycles: got %0d want %0d", name, nwe, ns);
        end
        total++;
        if (nmis != 0 || nover != 0) begin
            bad++;
            $display("FAIL %s strobe_consistency: got %0d we_a/we_b splits and %0d busy-with-done, want 0",
                     name, nmis, nover);
        end
        @(negedge clk_i);
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done: got done_o=%b busy_o=%b want 0 0", name, done_o, busy_o);
        end
        same = 1'b1;
        for (int i = 0; i < MAX; i++) if (mem[i] !== exp_o[i]) same = 1'b0;
        total++;
        if (!same) begin
            bad++;
            $display("FAIL %s ram_contents: got %p want %p", name, mem, exp_o);
        end
        total++;
        if (passes_o !== exp_p) begin
            bad++;
            $display("FAIL %s passes_o: got %0d want %0d", name, passes_o, exp_p);
        end
        total++;
        if (swaps_o !== exp_s) begin
            bad++;
            $display("FAIL %s swaps_o: got %0d want %0d", name, swaps_o, exp_s);
        end
    endtask

    task automatic test_reset();
        logic [RW-1:0] got_v, exp_v;
        logic [AW-1:0] z = '0, o = AW'(1);
        logic [2*AW-1:0] z2 = '0;
        srst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        got_v = {busy_o, done_o, we_a_o, we_b_o, addr_a_o, addr_b_o, passes_o, swaps_o};
        exp_v = {4'b0000, z, o, z, z2};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL reset_outputs: got %h want %h", got_v, exp_v);
        end
        srst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_plan_vectors();
        arr_t a;
        for (int i = 0; i < MAX; i++) a[i] = DW'($urandom);
        a[0] = 5; a[1] = 3; a[2] = 9; a[3] = 1;
        run_sort("asc_5391", a, 3, 1'b0, 1'b0);
        run_sort("desc_5391", a, 3, 1'b1, 1'b0);
        a[0] = 1; a[1] = 2; a[2] = 3; a[3] = 4;
        run_sort("presorted", a, 3, 1'b0, 1'b0);
        a[0] = 2; a[1] = 2; a[2] = 1;
        run_sort("duplicates", a, 2, 1'b0, 1'b0);
    endtask

    task automatic test_last_addr_zero();
        arr_t a;
        for (int i = 0; i < MAX; i++) a[i] = DW'($urandom);
        run_sort("last_addr_zero", a, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reversed16();
        arr_t a;
        for (int i = 0; i < MAX; i++) a[i] = DW'(MAX - 1 - i);
        run_sort("reversed16", a, MAX - 1, 1'b0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        arr_t a;
        for (int i = 0; i < MAX; i++) a[i] = DW'($urandom);
        run_sort("start_while_busy", a, 9, 1'b0, 1'b1);
        run_sort("start_while_busy_desc", a, 5, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        arr_t a;
        int   l;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < MAX; i++) a[i] = DW'($urandom_range(0, 7));
            l = $urandom_range(1, MAX - 1);
            run_sort("random", a, l, 1'($urandom), (l >= 2) ? 1'($urandom) : 1'b0);
        end
    endtask

    task automatic test_reset_mid_sort();
        arr_t a;
        logic [RW-1:0] got_v, exp_v;
        logic [AW-1:0] z = '0, o = AW'(1);
        logic [2*AW-1:0] z2 = '0;
        int nwe;
        bit ok;
        for (int i = 0; i < MAX; i++) a[i] = (i < 8) ? DW'(7 - i) : DW'($urandom);
        load_ram(a);
        @(negedge clk_i);
        start_i     = 1'b1;
        last_addr_i = AW'(7);
        desc_i      = 1'b0;
        @(negedge clk_i);
        start_i = 1'b0;
        // Now in cycle N+1; cycle N+5 is a read cycle.
        repeat (4) @(negedge clk_i);
        srst_i = 1'b1;
        #1;
        got_v = {busy_o, done_o, we_a_o, we_b_o, addr_a_o, addr_b_o, passes_o, swaps_o};
        exp_v = {4'b0000, z, o, z, z2};
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL midsort_reset_outputs: got %h want %h", got_v, exp_v);
        end
        nwe = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (we_a_o || we_b_o) nwe++;
        end
        total++;
        if (nwe != 0) begin
            bad++;
            $display("FAIL midsort_reset_writes: got %0d write cycles want 0", nwe);
        end
        srst_i = 1'b0;
        for (int i = 0; i < MAX; i++) a[i] = mem[i];
        run_sort("resort_after_reset", a, 7, 1'b0, 1'b0);
        ok = 1'b1;
        for (int i = 0; i < 8; i++) if (mem[i] !== DW'(i)) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL resort_final: got %p want 0..7 in words 0..7", mem);
        end
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_last_addr_zero();
        test_reversed16();
        test_start_while_busy();
        test_random();
        test_reset_mid_sort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
